// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RISC-V M-extension multiply/divide/remainder unit.
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per cycle.
//
// state | meaning
// IDLE  | waiting for MD_start
// CALC  | retiring UNROLL product/quotient bits per cycle
// FIX   | sign correction, result select and register
// DONE  | MD_done pulse; a new start is accepted here
module rv_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            MD_start,
    input  logic [2:0]      MD_funct3,
    input  logic [XLEN-1:0] MD_rs1_data,
    input  logic [XLEN-1:0] MD_rs2_data,
    input  logic            MD_kill,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_result
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]   ITER_CNT = CW'(N);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        funct3_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q;
    logic [CW-1:0]     cnt_q, cnt_dec;
    logic [2*XLEN-1:0] acc_q, acc_step, work;

    logic              rs1_signed, rs2_signed, neg_a, neg_b;
    logic              div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]   a_abs, b_abs, special_val, fix_result;
    logic [XLEN:0]     part, diff, sum;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_comb begin
        rs1_signed = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b010) ||
                     (MD_funct3 == 3'b100) || (MD_funct3 == 3'b110);
        rs2_signed = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b100) || (MD_funct3 == 3'b110);
        neg_a      = rs1_signed && MD_rs1_data[XLEN-1];
        neg_b      = rs2_signed && MD_rs2_data[XLEN-1];
        a_abs      = neg_a ? -MD_rs1_data : MD_rs1_data;
        b_abs      = neg_b ? -MD_rs2_data : MD_rs2_data;
        div_zero   = MD_funct3[2] && (MD_rs2_data == '0);
        div_ovf    = MD_funct3[2] && !MD_funct3[0] &&
                     (MD_rs1_data == INT_MIN) && (MD_rs2_data == '1);
        special    = div_zero || div_ovf;
        // funct3[1] separates rem/remu from div/divu
        if (div_zero)
            special_val = MD_funct3[1] ? MD_rs1_data : '1;
        else
            special_val = MD_funct3[1] ? '0 : MD_rs1_data;
        accept = ((state == IDLE) || (state == DONE)) && MD_start && !MD_kill;
    end

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        work = acc_q;
        part = '0;
        diff = '0;
        sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (funct3_q[2]) begin
                part = {work[2*XLEN-1:XLEN], work[XLEN-1]};
                diff = part - {1'b0, b_mag_q};
                if (diff[XLEN])
                    work = {part[XLEN-1:0], work[XLEN-2:0], 1'b0};
                else
                    work = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
            end else begin
                sum  = work[0] ? ({1'b0, work[2*XLEN-1:XLEN]} + {1'b0, a_mag_q})
                               : {1'b0, work[2*XLEN-1:XLEN]};
                work = {sum, work[XLEN-1:1]};
            end
        end
        acc_step = work;
    end

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_s  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (funct3_q)
            3'b000:                 fix_result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo_s;
            default:                fix_result = rem_s;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_dec   = cnt_q - CW'(1);
        unique case (state)
            IDLE, DONE: state_nxt = MD_start ? (special ? DONE : CALC) : IDLE;
            CALC:       if (cnt_dec == '0) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (MD_kill) state_nxt = IDLE;
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state     <= IDLE;
            funct3_q  <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            MD_busy   <= 1'b0;
            MD_done   <= 1'b0;
            MD_result <= '0;
        end else begin
            state   <= state_nxt;
            MD_busy <= (state_nxt == CALC) || (state_nxt == FIX);
            MD_done <= (state_nxt == DONE);
            if (accept) begin
                funct3_q <= MD_funct3;
                neg_a_q  <= neg_a;
                neg_b_q  <= neg_b;
                a_mag_q  <= a_abs;
                b_mag_q  <= b_abs;
                cnt_q    <= ITER_CNT;
                acc_q    <= {{XLEN{1'b0}}, (MD_funct3[2] ? a_abs : b_abs)};
                if (special) MD_result <= special_val;
            end else if ((state == CALC) && !MD_kill) begin
                acc_q <= acc_step;
                cnt_q <= cnt_dec;
            end else if ((state == FIX) && !MD_kill) begin
                MD_result <= fix_result;
            end
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed corner cases plus a random sweep,
// checked every cycle against an arithmetic reference model.
module tb_rv_muldiv_unit;
    localparam int N32 = 32;
    localparam int N16 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        kill = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    logic        start16 = 1'b0;
    logic [2:0]  f3_16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        kill16 = 1'b0;
    logic        busy16, done16;
    logic [15:0] res16;

    rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
        .SYS_clk(clk), .SYS_reset(rst_n), .MD_start(start), .MD_funct3(f3),
        .MD_rs1_data(rs1), .MD_rs2_data(rs2), .MD_kill(kill),
        .MD_busy(busy), .MD_done(done), .MD_result(result));

    rv_muldiv_unit #(.XLEN(16), .UNROLL(4)) dut16 (
        .SYS_clk(clk), .SYS_reset(rst_n), .MD_start(start16), .MD_funct3(f3_16),
        .MD_rs1_data(a16), .MD_rs2_data(b16), .MD_kill(kill16),
        .MD_busy(busy16), .MD_done(done16), .MD_result(res16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int          k;
        int          due;
        bit          special;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_result = '0;
    bit          mon_en = 1'b0;
    exp_t        mon_e;
    bit          busy_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_md(input int w, input logic [2:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, pu;
        longint          sa, sb, ps;
        logic [63:0]     r;
        bit              ovf;
        mask = (longint'(1) << w) - 1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        ovf  = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
        r    = '0;
        case (fn)
            3'd0: begin ps = sa * sb; r = ps; end
            3'd1: begin ps = sa * sb; r = ps; r = r >> w; end
            3'd2: begin ps = sa * longint'(ub); r = ps; r = r >> w; end
            3'd3: begin pu = ua * ub; r = pu >> w; end
            3'd4: begin
                if (ub == 0) r = mask;
                else if (ovf) r = ua;
                else begin ps = sa / sb; r = ps; end
            end
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: begin
                if (ub == 0) r = ua;
                else if (ovf) r = '0;
                else begin ps = sa % sb; r = ps; end
            end
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    function automatic bit is_special(input int w, input logic [2:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub;
        mask = (longint'(1) << w) - 1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        return fn[2] && ((ub == 0) ||
               (!fn[0] && (ua == (longint'(1) << (w - 1))) && (ub == mask)));
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m, v;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = m;
            2:       v = 32'd1 << (w - 1);
            3:       v = 32'($urandom_range(1, 20));
            4:       v = 32'd0 - 32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    // Every-cycle comparison of the 32-bit unit against the expectation queue.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", result, mon_e.res);
                    chk("done_cycle", cyc, mon_e.due);
                    last_result = mon_e.res;
                end
            end else begin
                chk("result_hold", result, last_result);
            end
            if ((q.size() > 0) && (cyc > q[0].due)) begin
                chk("missing_done", {31'b0, done}, 32'd1);
                void'(q.pop_front());
            end
            busy_exp = 1'b0;
            foreach (q[i])
                if (!q[i].special && (cyc > q[i].k) && (cyc < q[i].due)) busy_exp = 1'b1;
            chk("busy", {31'b0, busy}, {31'b0, busy_exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start     = 1'b1;
        f3        = fn;
        rs1       = a;
        rs2       = b;
        e.res     = ref_md(32, fn, a, b);
        e.special = is_special(32, fn, a, b);
        e.k       = cyc;
        e.due     = e.special ? cyc + 1 : cyc + N32 + 2;
        q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic wait_done();
        if (q.size() == 0) return;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            tick();
        end
        if (!done) chk("wait_done_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        issue(fn, a, b);
        drain();
    endtask

    task automatic op16(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] e32;
        int          due;
        e32     = ref_md(16, fn, {16'b0, a}, {16'b0, b});
        due     = is_special(16, fn, {16'b0, a}, {16'b0, b}) ? cyc + 1 : cyc + N16 + 2;
        start16 = 1'b1;
        f3_16   = fn;
        a16     = a;
        b16     = b;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done16) break;
        end
        chk("u4_done_cycle", cyc, due);
        chk("u4_result", {16'b0, res16}, e32);
        chk("u4_busy_done_excl", {31'b0, busy16 & done16}, 32'd0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  fn;
        logic [31:0] a, b;

        #3;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_result16", {16'b0, res16}, 32'd0);
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        chk("model_mul", ref_md(32, 3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_mulhsu", ref_md(32, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_rem", ref_md(32, 3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_mul16", ref_md(16, 3'd0, 32'd300, 32'd200), 32'h0000_EA60);

        run(3'd0, 32'd7, 32'hFFFF_FFFD);          chk("mul_7_m3", result, 32'hFFFF_FFEB);
        run(3'd1, 32'd7, 32'hFFFF_FFFD);          chk("mulh_7_m3", result, 32'hFFFF_FFFF);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  chk("mulhu_max", result, 32'hFFFF_FFFE);
        run(3'd0, 32'd5, 32'd3);                  chk("mul_5_3", result, 32'd15);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  chk("mulhsu_m1", result, 32'hFFFF_FFFF);
        run(3'd4, 32'hFFFF_FFF9, 32'd2);          chk("div_m7_2", result, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2);          chk("rem_m7_2", result, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7);                chk("divu_100_7", result, 32'd14);
        run(3'd7, 32'd100, 32'd7);                chk("remu_100_7", result, 32'd2);
        run(3'd4, 32'd5, 32'd0);                  chk("div_by_zero", result, 32'hFFFF_FFFF);
        run(3'd7, 32'd5, 32'd0);                  chk("remu_by_zero", result, 32'd5);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);  chk("div_ovf", result, 32'h8000_0000);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);  chk("rem_ovf", result, 32'd0);

        // back-to-back: next start presented during the DONE cycle
        issue(3'd5, 32'd1000, 32'd7);
        wait_done();
        issue(3'd7, 32'd1000, 32'd7);
        wait_done();
        issue(3'd4, 32'd9, 32'd0);
        drain();
        chk("b2b_special", result, 32'hFFFF_FFFF);

        // start pulses while calculating must be ignored
        issue(3'd0, 32'd12345, 32'd678);
        repeat (3) tick();
        start = 1'b1; f3 = 3'd4; rs1 = 32'd99; rs2 = 32'd0;
        repeat (4) tick();
        start = 1'b0;
        drain();
        chk("calc_start_ignored", result, 32'h007F_B6F6);

        // kill in CALC cycle 10
        issue(3'd6, 32'd1234567, 32'd89);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        q.delete();
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_result", result, 32'h007F_B6F6);
        repeat (5) tick();

        // kill together with start drops the start
        start = 1'b1; kill = 1'b1; f3 = 3'd4; rs1 = 32'd1; rs2 = 32'd0;
        tick();
        start = 1'b0; kill = 1'b0;
        repeat (3) tick();
        chk("kill_start_busy", {31'b0, busy}, 32'd0);
        chk("kill_start_result", result, 32'h007F_B6F6);

        // reset mid-CALC clears outputs immediately
        issue(3'd0, 32'd77, 32'd99);
        repeat (5) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        q.delete();
        last_result = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run(3'd0, 32'd77, 32'd99);
        chk("post_rst_mul", result, 32'h0000_1DC7);

        // UNROLL=4, XLEN=16 instance
        op16(3'd0, 16'd300, 16'd200);
        chk("u4_mul_300_200", {16'b0, res16}, 32'h0000_EA60);
        op16(3'd4, 16'd5, 16'd0);
        chk("u4_div_zero", {16'b0, res16}, 32'h0000_FFFF);
        for (int i = 0; i < 16; i++) begin
            fn = 3'($urandom_range(0, 7));
            a  = pick(16);
            b  = pick(16);
            op16(fn, a[15:0], b[15:0]);
        end

        // random sweep on the 32-bit instance, with occasional back-to-back issue
        for (int i = 0; i < 60; i++) begin
            fn = 3'($urandom_range(0, 7));
            a  = pick(32);
            b  = pick(32);
            if ($urandom_range(0, 3) == 0) wait_done();
            else drain();
            issue(fn, a, b);
        end
        drain();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
